// File: rtl/lsp_stability.sv
// In-place LSP stability pass: swap adjacent inversions, clamp both ends, enforce GAP3 spacing.
// All arithmetic is delegated to the shared external sub / L_sub / add units.
module lsp_stability #(
  parameter logic [10:0] BUF_BASE = 11'd0,
  parameter logic [15:0] L_LIMIT  = 16'd40,
  parameter logic [15:0] M_LIMIT  = 16'd25681,
  parameter logic [15:0] GAP3     = 16'd321
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] subIn,
  input  logic [31:0] L_subIn,
  input  logic [15:0] addIn,
  input  logic [31:0] memIn,
  output logic [15:0] subOutA,
  output logic [15:0] subOutB,
  output logic [31:0] L_subOutA,
  output logic [31:0] L_subOutB,
  output logic [15:0] addOutA,
  output logic [15:0] addOutB,
  output logic [31:0] memOut,
  output logic [10:0] memReadAddr,
  output logic [10:0] memWriteAddr,
  output logic        memWriteEn,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, P1_ADDR, P1_RDJ, P1_CMP, P1_SWP0, P1_SWP1, LL_ADDR, LL_CHK,
    P2_ADDR, P2_RDJ, P2_DIFF, P2_GAP, UL_ADDR, UL_CHK, DONE
  } state_t;

  state_t      state;
  logic [3:0]  j;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] diff;

  logic [3:0]  j1;
  logic [15:0] mem_word;
  logic        unused_bits;

  assign j1          = j + 4'd1;
  assign mem_word    = memIn[15:0];
  assign unused_bits = ^{memIn[31:16], subIn[14:0]};

  function automatic logic [10:0] addr_of(input logic [3:0] idx);
    return {BUF_BASE[10:4], idx};
  endfunction

  function automatic logic [31:0] sext(input logic [15:0] x);
    return {{16{x[15]}}, x};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      j     <= 4'd0;
      a     <= 16'd0;
      b     <= 16'd0;
      diff  <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          j     <= 4'd0;
          state <= P1_ADDR;
        end
        P1_ADDR: state <= P1_RDJ;
        P1_RDJ: begin
          a     <= mem_word;
          state <= P1_CMP;
        end
        P1_CMP: begin
          b <= mem_word;
          if (L_subIn[31]) begin
            state <= P1_SWP0;
          end else begin
            j     <= j1;
            state <= (j == 4'd8) ? LL_ADDR : P1_ADDR;
          end
        end
        P1_SWP0: state <= P1_SWP1;
        P1_SWP1: begin
          j     <= j1;
          state <= (j == 4'd8) ? LL_ADDR : P1_ADDR;
        end
        LL_ADDR: state <= LL_CHK;
        LL_CHK: begin
          j     <= 4'd0;
          state <= P2_ADDR;
        end
        P2_ADDR: state <= P2_RDJ;
        P2_RDJ: begin
          a     <= mem_word;
          state <= P2_DIFF;
        end
        P2_DIFF: begin
          diff  <= L_subIn;
          state <= P2_GAP;
        end
        P2_GAP: begin
          j     <= j1;
          state <= (j == 4'd8) ? UL_ADDR : P2_ADDR;
        end
        UL_ADDR: state <= UL_CHK;
        UL_CHK:  state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from state; anything not driven this cycle stays 0.
  always_comb begin
    subOutA      = 16'd0;
    subOutB      = 16'd0;
    L_subOutA    = 32'd0;
    L_subOutB    = 32'd0;
    addOutA      = 16'd0;
    addOutB      = 16'd0;
    memOut       = 32'd0;
    memReadAddr  = 11'd0;
    memWriteAddr = 11'd0;
    memWriteEn   = 1'b0;
    done         = 1'b0;
    case (state)
      P1_ADDR, P2_ADDR: memReadAddr = addr_of(j);
      P1_RDJ, P2_RDJ:   memReadAddr = addr_of(j1);
      P1_CMP, P2_DIFF: begin
        L_subOutA = sext(mem_word);
        L_subOutB = sext(a);
      end
      P1_SWP0: begin
        memWriteEn   = 1'b1;
        memWriteAddr = addr_of(j);
        memOut       = {16'd0, b};
      end
      P1_SWP1: begin
        memWriteEn   = 1'b1;
        memWriteAddr = addr_of(j1);
        memOut       = {16'd0, a};
      end
      LL_ADDR: memReadAddr = addr_of(4'd0);
      LL_CHK: begin
        subOutA = mem_word;
        subOutB = L_LIMIT;
        if (subIn[15]) begin
          memWriteEn   = 1'b1;
          memWriteAddr = addr_of(4'd0);
          memOut       = {16'd0, L_LIMIT};
        end
      end
      P2_GAP: begin
        L_subOutA = diff;
        L_subOutB = {16'd0, GAP3};
        if (L_subIn[31]) begin
          addOutA      = a;
          addOutB      = GAP3;
          memWriteEn   = 1'b1;
          memWriteAddr = addr_of(j1);
          memOut       = {16'd0, addIn};
        end
      end
      UL_ADDR: memReadAddr = addr_of(4'd9);
      UL_CHK: begin
        subOutA = M_LIMIT;
        subOutB = mem_word;
        if (subIn[15]) begin
          memWriteEn   = 1'b1;
          memWriteAddr = addr_of(4'd9);
          memOut       = {16'd0, M_LIMIT};
        end
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/lsp_stability.md
# lsp_stability

Hardware FSM for the G.729 `Lsp_stability` step of `Lsp_get_quant`. It runs on the 10-word LSP buffer after the expand stages (`Lsp_Expand_1`, `Lsp_Expand_2`) and `Lsp_prev_compose` have written it to scratch memory. The block reorders any adjacent inversions, clamps the low and high ends, and enforces the minimum spacing GAP3, all in place in memory. All arithmetic goes through the shared external math units, as in the other Qua_Lsp FSMs.

## Interface
- BUF_BASE, 11'd0: base word address of buf[0..9]. Bits [3:0] must be 0; the instantiation passes the LSP buffer constant.
- L_LIMIT, 16'd40: lower clamp for buf[0].
- M_LIMIT, 16'd25681: upper clamp for buf[9].
- GAP3, 16'd321: minimum spacing between adjacent entries.
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request, sampled in IDLE only.
- subIn  in  16  result of the external `sub`.
- L_subIn  in  32  result of the external `L_sub`.
- addIn  in  16  result of the external `add`.
- memIn  in  32  scratch read data; bits [15:0] are used.
- subOutA, subOutB  out  16  operands to `sub`.
- L_subOutA, L_subOutB  out  32  operands to `L_sub`.
- addOutA, addOutB  out  16  operands to `add`.
- memOut  out  32  write data: {16'd0, value}.
- memReadAddr, memWriteAddr  out  11  addresses, each {BUF_BASE[10:4], idx[3:0]}.
- memWriteEn  out  1  write strobe.
- done  out  1  one-cycle completion pulse.

## Operation
- Every output is combinational from state. Each output is 0 in any cycle that does not drive it, including after reset.
- Registers:
  - state
  - j (4-bit)
  - a (buf[j])
  - b (buf[j+1])
  - diff (32-bit)
- All registers reset to 0.
- Memory reads are synchronous: data appears on memIn the cycle after the address is driven.
- A write in cycle n is visible to a read addressed in cycle n+1.
- sext(x) means {{16{x[15]}}, x}.
- IDLE: on start=1, set j=0 and go to P1_ADDR. start is ignored in every other state.
- Pass 1 (inversion swap), j = 0..8:
  - P1_ADDR: read idx j.
  - P1_RDJ: a = memIn[15:0]; read idx j+1.
  - P1_CMP: b = memIn[15:0]; L_subOutA = sext(memIn[15:0]), L_subOutB = sext(a).
    - If L_subIn[31]=1, go to P1_SWP0.
    - Otherwise j++; go to P1_ADDR, or to LL_ADDR when j was 8.
  - P1_SWP0: write b to idx j.
  - P1_SWP1: write a to idx j+1; j++; go to P1_ADDR, or to LL_ADDR when j was 8.
- Lower clamp:
  - LL_ADDR: read idx 0.
  - LL_CHK: subOutA = memIn[15:0], subOutB = L_LIMIT. If subIn[15]=1, write L_LIMIT to idx 0 in the same cycle. Then set j=0 and go to P2_ADDR.
- Pass 2 (spacing), j = 0..8, strictly sequential:
  - P2_ADDR: read idx j.
  - P2_RDJ: a = memIn[15:0]; read idx j+1.
  - P2_DIFF: L_subOutA = sext(memIn[15:0]), L_subOutB = sext(a); diff = L_subIn.
  - P2_GAP: L_subOutA = diff, L_subOutB = {16'd0, GAP3}.
    - If L_subIn[31]=1: addOutA = a, addOutB = GAP3, memOut = {16'd0, addIn}, write to idx j+1. `add` saturates to 32767.
    - In either case j++; go to P2_ADDR, or to UL_ADDR when j was 8.
- Upper clamp:
  - UL_ADDR: read idx 9.
  - UL_CHK: subOutA = M_LIMIT, subOutB = memIn[15:0]. If subIn[15]=1 (buf[9] > M_LIMIT), write M_LIMIT to idx 9. Go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- No write ever addresses an index outside 0..9.

## Timing
- Call the cycle in which start=1 is sampled in IDLE cycle 0.
- Phase cycle counts:
  - Pass 1: 3 cycles per iteration, plus 2 per swap.
  - LL: 2 cycles.
  - Pass 2: 4 cycles per iteration, fixed.
  - UL: 2 cycles.
  - DONE: 1 cycle.
- done is high in cycle 68 + 2·S, where S is the number of pass-1 swaps (0..9). The block is back in IDLE in the next cycle.
- A start asserted in the DONE cycle is ignored; the block accepts a new start the cycle after done.
- Reset asserted in any state:
  - Next cycle: IDLE, all registers 0, no write issued.
  - A partially processed buffer is left as is; no rollback.

## Test plan
- Buffer 1000, 2000, …, 10000 → no memWriteEn at all; done in cycle 68; memory unchanged.
- Buffer 1000, 2000, 3000, 5000, 4000, 6000, …, 10000 → one swap (idx 3 = 4000, idx 4 = 5000); no other writes; done in cycle 70.
- buf[0]=10, others 1000, 2000, …, 9000 → idx 0 becomes 40; no spacing writes (1000 − 40 ≥ 321); done in cycle 68.
- Buffer 100, 200, …, 1000 → pass 2 chains to 100, 421, 742, …, 2989 (100 + 321·j); 9 writes; done in cycle 68.
- Buffer 1000, 2000, …, 9000, 30000 → idx 9 becomes 25681; done in cycle 68.
- Reset asserted in P2_GAP of iteration j=4 → IDLE next cycle; all outputs 0; entries 0..4 already written remain; a new start then completes normally.
